// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage: PC owner, imem req/ack fetch, buffered issue to decode
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_pc4,
    output logic        misalign_err
);
    localparam int            AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]   C_DEPTH = (AW+1)'(FIFO_DEPTH);
    localparam logic [31:0]   C_NOP   = 32'h0000_0013;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DRAIN} state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic            r_req;
    logic [31:0]     r_addr;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     w_addr_nx;
    logic [31:0]     w_fetch_nx;
    logic [31:0]     r_data [FIFO_DEPTH];
    logic [31:0]     r_pcs  [FIFO_DEPTH];
    logic [AW-1:0]   r_wptr;
    logic [AW-1:0]   r_rptr;
    logic [AW:0]     r_count;
    logic [AW:0]     w_count_nx;
    logic            r_valid;
    logic            r_mis;
    logic            w_push;
    logic            w_pop;
    logic [31:0]     w_target;

    assign w_target   = {redirect_pc[31:2], 2'b00};
    // Redirect wins over both FIFO ports: the whole buffer is stale.
    assign w_push     = (r_state == S_REQ) && imem_ack && !redirect_valid;
    assign w_pop      = r_valid && id_ready && !redirect_valid;
    assign w_count_nx = redirect_valid ? '0
                      : r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};

    always_comb begin
        w_state_nx = r_state;
        w_addr_nx  = r_addr;
        w_fetch_nx = r_fetch_pc;
        case (r_state)
            S_IDLE: begin
                if (redirect_valid) begin
                    w_state_nx = S_REQ;
                    w_addr_nx  = w_target;
                    w_fetch_nx = w_target;
                end else if (r_count < C_DEPTH) begin
                    w_state_nx = S_REQ;
                    w_addr_nx  = r_fetch_pc;
                end
            end
            S_REQ: begin
                if (redirect_valid) begin
                    w_fetch_nx = w_target;
                    if (imem_ack) begin
                        w_addr_nx = w_target;
                    end else begin
                        w_state_nx = S_DRAIN;
                    end
                end else if (imem_ack) begin
                    w_fetch_nx = r_addr + 32'd4;
                    // Keep requesting only while the next word has a reserved slot.
                    if (w_count_nx < C_DEPTH) begin
                        w_addr_nx = r_addr + 32'd4;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end
            end
            S_DRAIN: begin
                if (redirect_valid) begin
                    w_fetch_nx = w_target;
                end
                if (imem_ack) begin
                    w_state_nx = S_REQ;
                    w_addr_nx  = redirect_valid ? w_target : r_fetch_pc;
                end
            end
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_req      <= 1'b0;
            r_addr     <= RESET_PC;
            r_fetch_pc <= RESET_PC;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_mis      <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_req      <= (w_state_nx != S_IDLE);
            r_addr     <= w_addr_nx;
            r_fetch_pc <= w_fetch_nx;
            r_count    <= w_count_nx;
            r_valid    <= (w_count_nx != '0);
            if (redirect_valid && (redirect_pc[1:0] != 2'b00)) begin
                r_mis <= 1'b1;
            end
            if (redirect_valid) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + 1'b1;
                if (w_pop)  r_rptr <= r_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push && !reset) begin
            r_data[r_wptr] <= imem_rdata;
            r_pcs[r_wptr]  <= r_addr;
        end
    end

    assign imem_req     = r_req;
    assign imem_addr    = r_addr;
    assign inst_valid   = r_valid;
    assign misalign_err = r_mis;
    assign inst         = r_valid ? r_data[r_rptr] : C_NOP;
    assign inst_pc      = r_valid ? r_pcs[r_rptr] : 32'h0000_0000;
    assign inst_pc4     = inst_pc + 32'd4;
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - scoreboard bench for if_stage: directed fetch scenarios plus randomized traffic
module tb_if_stage;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        id_ready = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
    logic        misalign_err;

    if_stage #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_ready(id_ready),
        .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_pc4(inst_pc4),
        .misalign_err(misalign_err)
    );

    always #5 clock = ~clock;

    int          total = 0;
    int          bad = 0;
    int          ack_pct = 100;
    logic        blk_en = 1'b0;
    logic [31:0] blk_addr = 32'h0;
    logic        force_ack = 1'b0;
    logic [31:0] exp_q [$];
    logic        exp_mis = 1'b0;
    logic        started = 1'b0;
    int          accepted = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        total++;
        if (act !== exp_v) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", nm, act, exp_v);
        end
    endtask

    // Expected decode stream: consecutive words from the last reset/redirect target.
    task automatic load_stream(input logic [31:0] start);
        exp_q.delete();
        for (int i = 0; i < 512; i++) exp_q.push_back(start + 32'(4 * i));
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wait_req(input string nm, input bit match, input logic [31:0] addr,
                            input bit need_ack);
        for (int i = 0; i < 30; i++) begin
            @(negedge clock);
            if (imem_req && (!match || imem_addr == addr) && (!need_ack || imem_ack)) return;
        end
        total++;
        bad++;
        $display("FAIL %s: timeout waiting for imem_req addr=%h", nm, addr);
    endtask

    task automatic do_reset(input logic rdy);
        tick;
        reset = 1'b1;
        redirect_valid = 1'b0;
        force_ack = 1'b0;
        blk_en = 1'b0;
        ack_pct = 100;
        id_ready = rdy;
        load_stream(32'h0000_0000);
        tick;
        @(negedge clock);
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst", inst, 32'h13);
        chk("rst_pc", inst_pc, 32'h0);
        chk("rst_pc4", inst_pc4, 32'h4);
        chk("rst_mis", {31'b0, misalign_err}, 32'd0);
        started = 1'b0;
        tick;
        reset = 1'b0;
        started = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clock);
            #2;
            imem_ack = force_ack ||
                (imem_req && !(blk_en && imem_addr == blk_addr) &&
                 (int'($urandom_range(0, 99)) < ack_pct));
            imem_rdata = force_ack ? 32'hDEAD_BEEF : mem_word(imem_addr);
        end
    end

    logic        p_req = 1'b0;
    logic        p_ack = 1'b0;
    logic        p_redir = 1'b0;
    logic [31:0] p_addr = 32'h0;

    initial begin
        logic [31:0] pc;
        forever begin
            @(negedge clock);
            if (started && !reset) begin
                chk("misalign", {31'b0, misalign_err}, {31'b0, exp_mis});
                if (!inst_valid) chk("nop_when_invalid", inst, 32'h13);
                if (p_redir) chk("flush", {31'b0, inst_valid}, 32'd0);
                if (imem_req) chk("addr_align", {30'b0, imem_addr[1:0]}, 32'd0);
                if (p_req && !p_ack && imem_req) chk("addr_hold", imem_addr, p_addr);
                if (inst_valid && id_ready) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL stream: unexpected inst_pc=%h", inst_pc);
                    end else begin
                        pc = exp_q.pop_front();
                        chk("inst_pc", inst_pc, pc);
                        chk("inst", inst, mem_word(pc));
                        chk("inst_pc4", inst_pc4, pc + 32'd4);
                        accepted++;
                    end
                end
            end
            p_req   = imem_req && !reset && started;
            p_ack   = imem_ack;
            p_addr  = imem_addr;
            p_redir = redirect_valid && !reset;
            if (reset) exp_mis = 1'b0;
            else if (redirect_valid && redirect_pc[1:0] != 2'b00) exp_mis = 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          since;
        int          acc0;
        logic [31:0] tgt;

        // Back-to-back fetch with ack every cycle
        do_reset(1'b1);
        wait_req("b2b_first", 1'b0, 32'h0, 1'b0);
        chk("b2b_addr0", imem_addr, 32'h0);
        tick; @(negedge clock);
        chk("b2b_addr4", imem_addr, 32'h4);
        chk("b2b_pc0", inst_pc, 32'h0);
        chk("b2b_valid", {31'b0, inst_valid}, 32'd1);
        tick; @(negedge clock);
        chk("b2b_addr8", imem_addr, 32'h8);
        chk("b2b_pc4", inst_pc, 32'h4);
        chk("b2b_pc4_4", inst_pc4, 32'h8);
        tick; @(negedge clock);
        chk("b2b_pc8", inst_pc, 32'h8);
        chk("b2b_pc8_4", inst_pc4, 32'hC);

        // Decode stall fills the buffer and stops fetch
        do_reset(1'b0);
        repeat (7) tick;
        @(negedge clock);
        chk("stall_req", {31'b0, imem_req}, 32'd0);
        chk("stall_valid", {31'b0, inst_valid}, 32'd1);
        chk("stall_pc", inst_pc, 32'h0);
        tick;
        id_ready = 1'b1;
        wait_req("resume", 1'b0, 32'h0, 1'b0);
        chk("resume_addr", imem_addr, 32'h8);
        repeat (4) tick;

        // Redirect while a request is outstanding and unacked
        do_reset(1'b1);
        blk_addr = 32'h8;
        blk_en = 1'b1;
        wait_req("drain_wait", 1'b1, 32'h8, 1'b0);
        tick;
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        id_ready = 1'b0;
        load_stream(32'h100);
        tick;
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            chk("drain_valid", {31'b0, inst_valid}, 32'd0);
            chk("drain_addr", imem_addr, 32'h8);
            tick;
        end
        blk_en = 1'b0;
        wait_req("drain_next", 1'b0, 32'h0, 1'b0);
        chk("drain_addr_hold", imem_addr, 32'h8);
        tick; @(negedge clock);
        chk("drain_target", imem_addr, 32'h100);
        chk("drain_valid2", {31'b0, inst_valid}, 32'd0);
        repeat (6) tick;

        // Redirect in the same cycle as an ack
        do_reset(1'b1);
        wait_req("same_wait", 1'b1, 32'h8, 1'b1);
        tick;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        id_ready = 1'b0;
        load_stream(32'h200);
        @(negedge clock);
        chk("same_addr", imem_addr, 32'hC);
        chk("same_ack", {31'b0, imem_ack}, 32'd1);
        tick;
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        @(negedge clock);
        chk("same_next", imem_addr, 32'h200);
        chk("same_empty", {31'b0, inst_valid}, 32'd0);
        repeat (4) tick;

        // Misaligned redirect
        redirect_valid = 1'b1;
        redirect_pc = 32'h102;
        id_ready = 1'b0;
        load_stream(32'h100);
        tick;
        redirect_valid = 1'b0;
        id_ready = 1'b1;
        repeat (8) tick;
        @(negedge clock);
        chk("mis_sticky", {31'b0, misalign_err}, 32'd1);
        do_reset(1'b1);
        @(negedge clock);
        chk("mis_cleared", {31'b0, misalign_err}, 32'd0);

        // Reset during a pending request, late ack afterwards
        ack_pct = 0;
        wait_req("late_wait", 1'b0, 32'h0, 1'b0);
        tick;
        reset = 1'b1;
        load_stream(32'h0);
        tick;
        reset = 1'b0;
        force_ack = 1'b1;
        @(negedge clock);
        chk("late_valid", {31'b0, inst_valid}, 32'd0);
        chk("late_nop", inst, 32'h13);
        tick;
        force_ack = 1'b0;
        ack_pct = 100;
        @(negedge clock);
        chk("late_addr", imem_addr, 32'h0);
        chk("late_valid2", {31'b0, inst_valid}, 32'd0);
        chk("late_nop2", inst, 32'h13);
        repeat (6) tick;

        // Randomized traffic
        do_reset(1'b1);
        acc0 = accepted;
        since = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            tick;
            if (cyc % 300 == 0) ack_pct = int'($urandom_range(20, 100));
            since++;
            if ($urandom_range(0, 39) == 0 || since > 150) begin
                tgt = $urandom();
                if ($urandom_range(0, 7) == 0) tgt = {28'hFFFF_FFF, tgt[3:0]};
                if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
                redirect_valid = 1'b1;
                redirect_pc = tgt;
                id_ready = 1'b0;
                load_stream({tgt[31:2], 2'b00});
                since = 0;
            end else begin
                redirect_valid = 1'b0;
                id_ready = ($urandom_range(0, 3) != 0);
            end
        end
        tick;
        redirect_valid = 1'b0;
        repeat (3) tick;
        chk("progress", {31'b0, (accepted - acc0) > 500}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
Instruction fetch stage for the 32I pipeline. It owns the PC and fetches 32-bit words from instruction memory over a req/ack handshake. Fetched words are buffered in a small FIFO and presented to the decode stage with valid/ready flow control. Jump/branch redirects flush the FIFO and discard any stale in-flight response.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2)

Ports:
clock  input  1  sole clock, rising edge
reset  input  1  synchronous, active-high
imem_req  output  1  fetch request; held high until acked
imem_addr  output  32  word address of request; stable while imem_req=1
imem_ack  input  1  response valid; sampled only while imem_req=1
imem_rdata  input  32  instruction word, valid with imem_ack
redirect_valid  input  1  jump/branch taken this cycle
redirect_pc  input  32  new fetch PC
id_ready  output-consumer  input  1  decode accepts inst this cycle (0 = stall)
inst_valid  output  1  inst/inst_pc are valid
inst  output  32  instruction to decode; 32'h0000_0013 (NOP) when invalid
inst_pc  output  32  PC of inst
inst_pc4  output  32  inst_pc + 4 (wraps mod 2^32)
misalign_err  output  1  sticky: a redirect_pc had [1:0]!=0

Behaviour:
- Reset (sync, high): fetch_pc=RESET_PC, FIFO empty, state=IDLE, imem_req=0, imem_addr=RESET_PC, inst_valid=0, inst=NOP, inst_pc=0, inst_pc4=4, misalign_err=0. Reset mid-request drops the request; a late imem_ack after reset is ignored.
- States: IDLE, REQ, DRAIN. imem_req is registered: 1 exactly in REQ and DRAIN.
- IDLE: if no redirect and FIFO count < FIFO_DEPTH -> REQ next cycle with imem_addr=fetch_pc.
- REQ: on imem_ack (no redirect), push {imem_rdata, imem_addr} into FIFO, fetch_pc += 4 (wraps). Stay in REQ with the new address if count after this cycle's push/pop < FIFO_DEPTH; otherwise go to IDLE. Ack may arrive in the first REQ cycle, giving back-to-back throughput of 1 instr/cycle.
- Redirect (priority over push/pop):
  - The FIFO is flushed and inst_valid=0 from the next cycle.
  - fetch_pc={redirect_pc[31:2],2'b00}. If redirect_pc[1:0]!=0, misalign_err is set (sticky until reset).
  - In REQ without ack that cycle -> DRAIN. In DRAIN, imem_req stays high with the old address until ack; the response is discarded, then -> REQ at the redirect PC.
  - In REQ with ack the same cycle, the data is discarded and the next state is REQ at the redirect PC.
  - In IDLE -> REQ at the redirect PC.
  - A redirect while in DRAIN updates the target only; the state stays DRAIN.
- Decode side: inst_valid=(count!=0). inst, inst_pc and inst_pc4 come from the FIFO head. Pop when inst_valid & id_ready. A simultaneous push and pop when full is legal and the count is unchanged. A push into an empty FIFO is visible one cycle after the ack cycle.
- Outputs other than inst/inst_pc/inst_pc4 are registered. Head data may be a combinational read of FIFO storage.
- The FIFO never overflows: a request is issued only when a slot is guaranteed, i.e. count + outstanding <= FIFO_DEPTH.

Test Plan:
- Reset, then ack every REQ cycle, id_ready=1 -> imem_addr 0x0,0x4,0x8 on consecutive cycles. inst_pc follows 0x0,0x4,0x8 one cycle later. inst_pc4=0x4,0x8,0xC.
- id_ready=0 with a 2-deep FIFO -> two words buffered, then imem_req drops. Raising id_ready pops inst_pc 0x0 then 0x4, and fetch resumes at 0x8.
- Redirect to 0x100 while a REQ at 0x8 is unacked, ack 3 cycles later -> word for 0x8 never appears on inst. The next imem_addr is 0x100, and inst_valid=0 until its ack.
- Redirect to 0x200 in the same cycle as the ack for 0xC -> 0xC dropped, the next request is to 0x200, and the FIFO is empty.
- Redirect to 0x102 -> misalign_err=1 and persists, fetch at 0x100. A later reset clears misalign_err.
- Assert reset during REQ with a pending ack, then ack next cycle -> ignored. The first post-reset imem_addr is RESET_PC and inst=NOP while invalid.
